// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and default widths.
// Imported by the ALU arbiter and its round-robin sub-module.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SHL  = 4'b1000;
  localparam logic [3:0] ALU_SHR  = 4'b1001;
  localparam logic [3:0] ALU_SAR  = 4'b1010;
  localparam logic [3:0] ALU_ADD  = 4'b1011;
  localparam logic [3:0] ALU_SUB  = 4'b1100;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a single priority pointer flop.
// Pointer names the favoured requester; it moves to the loser on any grant.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_elig,
  output logic [1:0] o_grant
);

  logic r_ptr;

  // Grant: lone eligible requester wins, ties go to the pointer.
  always_comb begin
    o_grant = 2'b00;
    unique case (i_elig)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  // Pointer moves to the non-granted requester; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= 1'b0;
    else if (|o_grant)
      r_ptr <= o_grant[0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between execute (0) and branch unit (1).
// Optional grant counters enabled by defining ALU_ARB_PERF_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int              DATA_W  = ALU_DATA_W,
  parameter int              OP_W    = ALU_OP_W,
  parameter logic [OP_W-1:0] OP_IDLE = OP_W'(ALU_NOP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_rs,
  input  logic [2*DATA_W-1:0] req_rt,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [2*DATA_W-1:0] resp_rd,
  output logic [1:0]          resp_zf,
  output logic [1:0]          resp_of,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_rs,
  output logic [DATA_W-1:0]   alu_rt,
  input  logic [DATA_W-1:0]   alu_rd,
  input  logic                alu_zf,
  input  logic                alu_of,
  output logic [31:0]         perf_grant0,
  output logic [31:0]         perf_grant1
);

  logic [1:0]          w_elig;
  logic [1:0]          w_grant;
  logic [1:0]          r_vld;
  logic [2*DATA_W-1:0] r_rd;
  logic [1:0]          r_zf;
  logic [1:0]          r_of;

  // A full slot that is not draining blocks its requester.
  assign w_elig = req_valid & (~r_vld | resp_ready);

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_elig  (w_elig),
    .o_grant (w_grant)
  );

  assign req_ready  = w_grant;
  assign resp_valid = r_vld;
  assign resp_rd    = r_rd;
  assign resp_zf    = r_zf;
  assign resp_of    = r_of;

  // Route the granted requester's fields to the ALU.
  always_comb begin
    alu_op = OP_IDLE;
    alu_rs = '0;
    alu_rt = '0;
    unique case (1'b1)
      w_grant[0]: begin
        alu_op = req_op[0 +: OP_W];
        alu_rs = req_rs[0 +: DATA_W];
        alu_rt = req_rt[0 +: DATA_W];
      end
      w_grant[1]: begin
        alu_op = req_op[OP_W +: OP_W];
        alu_rs = req_rs[DATA_W +: DATA_W];
        alu_rt = req_rt[DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // Response slots: load on grant, else clear on drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_rd  <= '0;
      r_zf  <= '0;
      r_of  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i]) begin
          r_vld[i]                <= 1'b1;
          r_rd[i*DATA_W +: DATA_W] <= alu_rd;
          r_zf[i]                 <= alu_zf;
          r_of[i]                 <= alu_of;
        end else if (resp_ready[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [31:0] r_perf0;
  logic [31:0] r_perf1;

  // Free-running grant counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf0 <= '0;
      r_perf1 <= '0;
    end else begin
      if (w_grant[0]) r_perf0 <= r_perf0 + 32'd1;
      if (w_grant[1]) r_perf1 <= r_perf1 + 32'd1;
    end
  end

  assign perf_grant0 = r_perf0;
  assign perf_grant1 = r_perf1;
`else
  assign perf_grant0 = '0;
  assign perf_grant1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU, transaction model, directed vectors.
// Perf expectations follow ALU_ARB_PERF_EN when it is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  req_valid = 0;
  logic [1:0]  req_ready;
  logic [7:0]  req_op = 0;
  logic [63:0] req_rs = 0;
  logic [63:0] req_rt = 0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 0;
  logic [63:0] resp_rd;
  logic [1:0]  resp_zf;
  logic [1:0]  resp_of;
  logic [3:0]  alu_op;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [31:0] alu_rd;
  logic        alu_zf;
  logic        alu_of;
  logic [31:0] perf_grant0;
  logic [31:0] perf_grant1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_zf(resp_zf), .resp_of(resp_of),
    .alu_op(alu_op), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_rd(alu_rd), .alu_zf(alu_zf), .alu_of(alu_of),
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1)
  );

  // Reference ALU: returns {of, zf, rd}.
  function automatic logic [33:0] alu_f(logic [3:0] op,
                                        logic [31:0] a,
                                        logic [31:0] b);
    logic [31:0] r;
    logic        o;
    r = 0;
    o = 0;
    case (op)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADDU: r = a + b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SUBU: r = a - b;
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SHL:  r = a << b[4:0];
      ALU_SHR:  r = a >> b[4:0];
      ALU_SAR:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_ADD: begin
        r = a + b;
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        r = a - b;
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = 0;
    endcase
    return {o, (r == 0), r};
  endfunction

  always_comb begin
    {alu_of, alu_zf, alu_rd} = alu_f(alu_op, alu_rs, alu_rt);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction model: slot contents, who was served last, grant counts.
  logic        m_vld[2] = '{0, 0};
  logic [31:0] m_rd[2]  = '{0, 0};
  logic        m_zf[2]  = '{0, 0};
  logic        m_of[2]  = '{0, 0};
  int          m_last = 1;
  int unsigned m_cnt[2] = '{0, 0};

  function automatic logic [1:0] m_grant();
    logic [1:0] e;
    for (int i = 0; i < 2; i++)
      e[i] = req_valid[i] && (!m_vld[i] || resp_ready[i]);
    if (e == 2'b11)
      return (m_last == 0) ? 2'b10 : 2'b01;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0]  g;
    logic [33:0] res;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_vld[i] = 0; m_rd[i] = 0; m_zf[i] = 0; m_of[i] = 0;
        m_cnt[i] = 0;
      end
      m_last = 1;
    end else begin
      g = m_grant();
      for (int i = 0; i < 2; i++) begin
        if (g[i]) begin
          res = alu_f(req_op[i*4 +: 4], req_rs[i*32 +: 32],
                      req_rt[i*32 +: 32]);
          m_vld[i] = 1;
          m_rd[i]  = res[31:0];
          m_zf[i]  = res[32];
          m_of[i]  = res[33];
          m_cnt[i]++;
          m_last = i;
        end else if (resp_ready[i]) begin
          m_vld[i] = 0;
        end
      end
    end
  end

  // Compare every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] g;
    int         s;
    if (rst_n) begin
      g = m_grant();
      s = g[1] ? 1 : 0;
      chk("req_ready", req_ready, g);
      chk("alu_op", alu_op, (g != 0) ? req_op[s*4 +: 4] : ALU_NOP);
      chk("alu_rs", alu_rs, (g != 0) ? req_rs[s*32 +: 32] : 0);
      chk("alu_rt", alu_rt, (g != 0) ? req_rt[s*32 +: 32] : 0);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("resp_valid%0d", i), resp_valid[i], m_vld[i]);
        chk($sformatf("resp_rd%0d", i), resp_rd[i*32 +: 32], m_rd[i]);
        chk($sformatf("resp_zf%0d", i), resp_zf[i], m_zf[i]);
        chk($sformatf("resp_of%0d", i), resp_of[i], m_of[i]);
      end
`ifdef ALU_ARB_PERF_EN
      chk("perf0", perf_grant0, m_cnt[0]);
      chk("perf1", perf_grant1, m_cnt[1]);
`else
      chk("perf0", perf_grant0, 0);
      chk("perf1", perf_grant1, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req_op[3:0] = op; req_rs[31:0] = a; req_rt[31:0] = b;
  endtask

  task automatic set1(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req_op[7:4] = op; req_rs[63:32] = a; req_rt[63:32] = b;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", resp_valid, 2'b00);
    chk("rst_rd", resp_rd, 64'd0);
    tick();
    rst_n = 1;
    resp_ready = 2'b11;

    // Single request
    set0(ALU_ADDU, 5, 7);
    req_valid = 2'b01;
    @(negedge clk);
    chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_valid", resp_valid, 2'b01);
    chk("t1_rd", resp_rd[31:0], 32'd12);
    chk("t1_zf", resp_zf[0], 1'b0);
    chk("t1_of", resp_of[0], 1'b0);

    // Contention after reset
    tick(); rst_n = 0;
    tick(); rst_n = 1;
    set0(ALU_ADDU, 1, 1);
    set1(ALU_SUBU, 3, 3);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t2_g0", req_ready, 2'b01);
    tick();
    @(negedge clk);
    chk("t2_g1", req_ready, 2'b10);
    chk("t2_rd0", resp_rd[31:0], 32'd2);
    tick();
    @(negedge clk);
    chk("t2_g2", req_ready, 2'b01);
    chk("t2_rd1", resp_rd[63:32], 32'd0);
    chk("t2_zf1", resp_zf[1], 1'b1);
    tick();
    req_valid = 2'b00;
    tick();

    // Backpressure on requester 0
    resp_ready = 2'b10;
    set0(ALU_ADDU, 10, 20);
    req_valid = 2'b01;
    @(negedge clk);
    chk("t3_first", req_ready, 2'b01);
    tick();
    set0(ALU_ADDU, 100, 1);
    set1(ALU_XOR, 32'hF0, 32'h0F);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t3_blk_a", req_ready, 2'b10);
    chk("t3_hold_a", resp_rd[31:0], 32'd30);
    tick();
    @(negedge clk);
    chk("t3_blk_b", req_ready, 2'b10);
    chk("t3_hold_b", resp_rd[31:0], 32'd30);
    tick();
    resp_ready = 2'b11;
    @(negedge clk);
    chk("t3_reen", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t3_rd0", resp_rd[31:0], 32'd101);
    chk("t3_rd1", resp_rd[63:32], 32'hFF);

    // Overflow pass-through
    tick();
    set1(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t4_rd1", resp_rd[63:32], 32'h8000_0000);
    chk("t4_of1", resp_of[1], 1'b1);

    // Reset mid-operation
    tick();
    resp_ready = 2'b00;
    set0(ALU_ADDU, 2, 3);
    set1(ALU_SUBU, 9, 4);
    req_valid = 2'b11;
    tick();
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t5_full", resp_valid, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("t5_async", resp_valid, 2'b00);
    chk("t5_rd", resp_rd, 64'd0);
    tick();
    rst_n = 1;
    resp_ready = 2'b11;
    set0(ALU_ADDU, 1, 2);
    set1(ALU_SUBU, 5, 1);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t5_first", req_ready, 2'b01);

    // Five alternating grants: three to 0, two to 1
    repeat (4) tick();
    tick();
    req_valid = 2'b00;
    @(negedge clk);
`ifdef ALU_ARB_PERF_EN
    chk("t6_perf0", perf_grant0, 32'd3);
    chk("t6_perf1", perf_grant1, 32'd2);
`else
    chk("t6_perf0", perf_grant0, 32'd0);
    chk("t6_perf1", perf_grant1, 32'd0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
